// File: rtl/sprite_frame_writer.sv
// rtl/sprite_frame_writer.sv - per-frame write sweeper: sprite priority select, ROM lookup, frame-buffer write
module sprite_frame_writer #(
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int NUM_SPR = 4,
    parameter int ROM_LAT = 1,
    parameter int PIX_W   = 4,
    parameter logic [PIX_W-1:0] TRANSPARENT = 4'h0,
    parameter logic [PIX_W-1:0] BG_COLOR    = 4'h1
) (
    input  logic                  Clk50,
    input  logic                  Reset_n,
    input  logic                  frame_start,
    output logic [9:0]            WriteX,
    output logic [9:0]            WriteY,
    input  logic [NUM_SPR-1:0]    spr_on_wr,
    input  logic [NUM_SPR*18-1:0] spr_addr,
    output logic [17:0]           rom_addr,
    input  logic [PIX_W-1:0]      rom_data,
    output logic                  fb_we,
    output logic [18:0]           fb_addr,
    output logic [PIX_W-1:0]      fb_data,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SWEEP = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [9:0]  X_LAST     = 10'(H_RES - 1);
    localparam logic [9:0]  Y_LAST     = 10'(V_RES - 1);
    localparam logic [18:0] H_RES_W    = 19'(H_RES);
    localparam logic [7:0]  DRAIN_LAST = 8'(ROM_LAT + 1);

    logic [1:0]  state;
    logic [7:0]  drain_cnt;
    logic        pixel_valid;
    logic        sel_hit;
    logic [17:0] sel_addr;
    logic [18:0] pix_fb_addr;

    // Pipeline stage k carries the pixel issued k+1 cycles earlier.
    logic [ROM_LAT:0]       pipe_valid;
    logic [ROM_LAT:0]       pipe_hit;
    logic [ROM_LAT:0][18:0] pipe_addr;

    assign pixel_valid = (state == ST_SWEEP);
    assign pix_fb_addr = 19'(WriteY) * H_RES_W + 19'(WriteX);
    assign busy        = (state == ST_SWEEP) || (state == ST_DRAIN);
    assign done        = (state == ST_DONE);

    // Walk from the lowest priority upward so the lowest index ends up winning.
    always_comb begin
        sel_hit  = 1'b0;
        sel_addr = '0;
        for (int i = NUM_SPR - 1; i >= 0; i--) begin
            if (spr_on_wr[i]) begin
                sel_hit  = 1'b1;
                sel_addr = spr_addr[18*i +: 18];
            end
        end
    end

    always_ff @(posedge Clk50 or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= ST_IDLE;
            drain_cnt <= '0;
            WriteX    <= '0;
            WriteY    <= '0;
            overrun   <= 1'b0;
        end else begin
            if (frame_start) begin
                overrun <= (state != ST_IDLE);
            end
            case (state)
                ST_IDLE: begin
                    WriteX <= '0;
                    WriteY <= '0;
                    if (frame_start) begin
                        state <= ST_SWEEP;
                    end
                end
                ST_SWEEP: begin
                    if (WriteX == X_LAST) begin
                        WriteX <= '0;
                        if (WriteY == Y_LAST) begin
                            WriteY    <= '0;
                            drain_cnt <= '0;
                            state     <= ST_DRAIN;
                        end else begin
                            WriteY <= WriteY + 10'd1;
                        end
                    end else begin
                        WriteX <= WriteX + 10'd1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= ST_DONE;
                    end else begin
                        drain_cnt <= drain_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk50 or negedge Reset_n) begin
        if (!Reset_n) begin
            pipe_valid <= '0;
            pipe_hit   <= '0;
            pipe_addr  <= '0;
            rom_addr   <= '0;
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_data    <= '0;
        end else begin
            pipe_valid[0] <= pixel_valid;
            pipe_hit[0]   <= pixel_valid && sel_hit;
            pipe_addr[0]  <= pix_fb_addr;
            if (pixel_valid && sel_hit) begin
                rom_addr <= sel_addr;
            end
            for (int k = 1; k <= ROM_LAT; k++) begin
                pipe_valid[k] <= pipe_valid[k-1];
                pipe_hit[k]   <= pipe_hit[k-1];
                pipe_addr[k]  <= pipe_addr[k-1];
            end
            fb_we <= pipe_valid[ROM_LAT];
            if (pipe_valid[ROM_LAT]) begin
                fb_addr <= pipe_addr[ROM_LAT];
                // A transparent top sprite falls through to background, not to lower sprites.
                fb_data <= (pipe_hit[ROM_LAT] && (rom_data != TRANSPARENT)) ? rom_data : BG_COLOR;
            end
        end
    end

endmodule

// File: tb/tb_sprite_frame_writer.sv
// tb/tb_sprite_frame_writer.sv - scoreboard bench for sprite_frame_writer on a reduced screen
module tb_sprite_frame_writer;

    localparam int H    = 160;
    localparam int V    = 60;
    localparam int NPIX = H * V;

    logic        Clk50 = 1'b0;
    logic        Reset_n = 1'b0;
    logic        frame_start = 1'b0;
    logic [9:0]  WriteX, WriteY;
    logic [3:0]  spr_on_wr;
    logic [71:0] spr_addr;
    logic [17:0] rom_addr;
    logic [3:0]  rom_data = 4'h0;
    logic        fb_we;
    logic [18:0] fb_addr;
    logic [3:0]  fb_data;
    logic        busy, done, overrun;
    logic        spr_en = 1'b0;

    sprite_frame_writer #(.H_RES(H), .V_RES(V)) dut (
        .Clk50(Clk50), .Reset_n(Reset_n), .frame_start(frame_start),
        .WriteX(WriteX), .WriteY(WriteY), .spr_on_wr(spr_on_wr), .spr_addr(spr_addr),
        .rom_addr(rom_addr), .rom_data(rom_data), .fb_we(fb_we), .fb_addr(fb_addr),
        .fb_data(fb_data), .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 Clk50 = ~Clk50;

    int cyc = 0;
    always @(posedge Clk50) cyc <= cyc + 1;

    function automatic logic [3:0] rom_f(input logic [17:0] a);
        if (a == 18'h20000) return 4'h0;
        return {a[3:1], 1'b1};
    endfunction

    always @(posedge Clk50) rom_data <= rom_f(rom_addr);

    function automatic logic [3:0] spr_on(input int x, input int y, input logic en);
        logic [3:0] on = '0;
        if (en) begin
            if (y == 10 && (x == 10 || x == 20)) on[1:0] = 2'b11;
            if (x >= 100 && x <= 149 && y >= 20 && y <= 39) on[2] = 1'b1;
        end
        return on;
    endfunction

    function automatic logic [71:0] spr_ad(input int x, input int y);
        logic [71:0] ad = '0;
        ad[17:0]  = (x == 10) ? 18'd7 : 18'h20000;
        ad[35:18] = (x == 10) ? 18'd5000 : 18'd5;
        if (x >= 100 && x <= 149 && y >= 20 && y <= 39) ad[53:36] = 18'((y - 20) * 50 + (x - 100));
        return ad;
    endfunction

    always_comb begin
        spr_on_wr = spr_on(int'(WriteX), int'(WriteY), spr_en);
        spr_addr  = spr_ad(int'(WriteX), int'(WriteY));
    end

    function automatic logic [3:0] exp_pix(input int x, input int y, input logic en);
        logic [3:0]  on = spr_on(x, y, en);
        logic [71:0] ad = spr_ad(x, y);
        logic [3:0]  d;
        for (int i = 0; i < 4; i++) begin
            if (on[i]) begin
                d = rom_f(ad[18*i +: 18]);
                return (d != 4'h0) ? d : 4'h1;
            end
        end
        return 4'h1;
    endfunction

    typedef struct packed {
        logic [18:0] a;
        logic [3:0]  d;
    } exp_t;

    exp_t q[$];
    exp_t e;

    // Hand-computed pixels for the sprite frames: {fb_addr, fb_data}.
    localparam int NDIR = 8;
    logic [18:0] dir_a [NDIR] = '{19'd1610, 19'd1620, 19'd3300, 19'd3302, 19'd3463, 19'd3299, 19'd6389, 19'd6390};
    logic [3:0]  dir_d [NDIR] = '{4'h7, 4'h1, 4'h1, 4'h3, 4'h5, 4'h1, 4'h7, 4'h1};

    int checks = 0;
    int failures = 0;
    int nwr = 0;
    int nwr_base = 0;
    int start_cyc = 0;
    int done_cnt = 0;
    logic [18:0] last_addr = '0;
    logic prev_we = 1'b0;
    logic prev_busy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    always @(negedge Clk50) begin
        if (Reset_n) begin
            if (fb_we) begin
                nwr++;
                if (q.size() == 0) begin
                    chk("unexpected_fb_we_addr", 32'(fb_addr), 32'h7fffffff);
                end else begin
                    e = q.pop_front();
                    chk("fb_addr", 32'(fb_addr), 32'(e.a));
                    chk("fb_data", 32'(fb_data), 32'(e.d));
                end
                if (nwr - nwr_base == 1) chk("first_write_latency", 32'(cyc), 32'(start_cyc + 4));
                if (spr_en) begin
                    for (int i = 0; i < NDIR; i++) begin
                        if (fb_addr == dir_a[i]) chk("directed_pixel", 32'(fb_data), 32'(dir_d[i]));
                    end
                    if (fb_addr == 19'd1610) chk("priority_rom_addr", 32'(rom_addr), 32'd7);
                end
                last_addr = fb_addr;
            end
            if (done) begin
                done_cnt++;
                chk("done_after_last_we", 32'(prev_we), 32'd1);
                chk("write_count", 32'(nwr - nwr_base), 32'(NPIX));
                chk("last_fb_addr", 32'(last_addr), 32'(NPIX - 1));
                chk("busy_falls_at_done", {30'd0, prev_busy, busy}, 32'd2);
                chk("queue_empty_at_done", 32'(q.size()), 32'd0);
            end
            prev_we   = fb_we;
            prev_busy = busy;
        end
    end

    task automatic start_frame();
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
                q.push_back('{a: 19'(y * H + x), d: exp_pix(x, y, spr_en)});
        nwr_base    = nwr;
        start_cyc   = cyc;
        frame_start = 1'b1;
        @(negedge Clk50);
        frame_start = 1'b0;
    endtask

    task automatic wait_done();
        int base = done_cnt;
        int n = 0;
        while (done_cnt == base && n < NPIX + 100) begin
            @(negedge Clk50);
            n++;
        end
        chk("done_seen", 32'(done_cnt != base), 32'd1);
        repeat (5) @(negedge Clk50);
        chk("done_once", 32'(done_cnt - base), 32'd1);
    endtask

    initial begin
        Reset_n     = 1'b0;
        frame_start = 1'b1;
        repeat (3) @(negedge Clk50);
        chk("rst_WriteX", 32'(WriteX), 32'd0);
        chk("rst_WriteY", 32'(WriteY), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_fb_addr", 32'(fb_addr), 32'd0);
        chk("rst_fb_data", 32'(fb_data), 32'd0);
        chk("rst_flags", {28'd0, fb_we, busy, done, overrun}, 32'd0);
        frame_start = 1'b0;
        Reset_n     = 1'b1;
        repeat (100) @(negedge Clk50);
        chk("idle_after_reset_busy", 32'(busy), 32'd0);
        chk("idle_no_writes", 32'(nwr), 32'd0);

        spr_en = 1'b0;
        start_frame();
        wait_done();

        spr_en = 1'b1;
        start_frame();
        wait_done();

        start_frame();
        repeat (999) @(negedge Clk50);
        frame_start = 1'b1;
        @(negedge Clk50);
        frame_start = 1'b0;
        chk("overrun_set", 32'(overrun), 32'd1);
        chk("sweep_continues", 32'(busy), 32'd1);
        wait_done();
        chk("overrun_sticky", 32'(overrun), 32'd1);

        start_frame();
        chk("overrun_cleared", 32'(overrun), 32'd0);
        repeat (4999) @(negedge Clk50);
        Reset_n = 1'b0;
        #1;
        chk("midreset_fb_we", 32'(fb_we), 32'd0);
        chk("midreset_busy", 32'(busy), 32'd0);
        q.delete();
        repeat (2) @(negedge Clk50);
        Reset_n = 1'b1;
        nwr_base = nwr;
        repeat (100) @(negedge Clk50);
        chk("no_writes_after_midreset", 32'(nwr - nwr_base), 32'd0);
        chk("idle_after_midreset", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sprite_frame_writer.md
Name: sprite_frame_writer

Overview:
- Write-side sweeper for the sprite pipeline. Once per frame it walks WriteX/WriteY over the full screen and feeds them to every draw_* sprite module.
- It collects each module's on_wr flag and ROM address, picks the top-priority sprite, and reads the shared sprite ROM.
- It writes the resulting palette index (or background) into the frame buffer.
- Sits between the sprite modules, the sprite ROM and the frame-buffer SRAM port; it is kicked by a frame_Clk-derived pulse.

Parameters:
- H_RES, 640, pixels per line.
- V_RES, 480, lines per frame.
- NUM_SPR, 4, number of sprite sources; index 0 is the highest priority.
- ROM_LAT, 1, cycles from rom_addr to rom_data valid; must be >= 1.
- PIX_W, 4, palette index width.
- TRANSPARENT, 4'h0, palette index treated as see-through.
- BG_COLOR, 4'h1, index written where no opaque sprite pixel exists.

Ports:
- Clk50  in  1  system clock; all logic on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  single-cycle request to render one frame (Clk50 domain).
- WriteX  out  10  current sweep column.
- WriteY  out  10  current sweep row.
- spr_on_wr  in  NUM_SPR  per-sprite hit flags for the current WriteX/WriteY (combinational from sprite modules).
- spr_addr  in  NUM_SPR*18  per-sprite ROM addresses; sprite i occupies bits [18i+17:18i].
- rom_addr  out  18  sprite ROM read address.
- rom_data  in  PIX_W  sprite ROM read data.
- fb_we  out  1  frame-buffer write strobe.
- fb_addr  out  19  frame-buffer address, WriteY*H_RES+WriteX.
- fb_data  out  PIX_W  palette index to write.
- busy  out  1  high in SWEEP and DRAIN.
- done  out  1  one-cycle pulse when the last write has issued.
- overrun  out  1  sticky; frame_start arrived while busy.

Behaviour:
- Reset (async, Reset_n=0):
  - State goes to IDLE.
  - WriteX, WriteY, rom_addr, fb_addr, fb_data all 0.
  - fb_we, busy, done, overrun all 0.
  - Pipeline valid bits are cleared.
  - Asserting reset mid-frame abandons the frame; no further fb_we after release until a new frame_start.
- States:
  - IDLE: WriteX=WriteY=0. frame_start=1 -> SWEEP next cycle and clear overrun.
  - SWEEP: one pixel per cycle. WriteX increments. At WriteX==H_RES-1 it wraps to 0 and WriteY increments. At (H_RES-1, V_RES-1) -> DRAIN next cycle, with WriteX/WriteY returning to 0.
  - DRAIN: no new pixels issued. Stays until the pipeline is empty (ROM_LAT+2 cycles), then -> DONE.
  - DONE: done=1 for exactly one cycle, then -> IDLE.
- frame_start while in SWEEP, DRAIN or DONE: ignored (no restart) and sets overrun. overrun holds until the next accepted frame_start.
- Pipeline, for a pixel presented on WriteX/WriteY in cycle t:
  - Select: the lowest index i with spr_on_wr[i]=1 wins.
  - Cycle t+1: rom_addr = spr_addr[i] (registered); the hit flag and fb address are pipelined alongside. If there is no hit, rom_addr holds its previous value and hit=0.
  - Cycle t+1+ROM_LAT: rom_data is valid.
  - Cycle t+2+ROM_LAT: fb_we=1, fb_addr = Y*H_RES+X, and fb_data is:
    - rom_data, if hit and rom_data != TRANSPARENT;
    - BG_COLOR otherwise.
  - Default latency from pixel to write is 3 cycles.
- Every SWEEP cycle yields exactly one write: H_RES*V_RES = 307200 writes per frame, fb_addr strictly increasing from 0 to 307199, no gaps or duplicates.
- fb_we=0 at all other times.
- done asserts in the cycle after the final fb_we.
- Transparency is single-pass: a transparent top sprite does NOT reveal a lower-priority sprite; background is written.
- Arithmetic: fb_addr is computed with 19-bit unsigned math. WriteX/WriteY never exceed H_RES-1 / V_RES-1.

Test Plan:
- Reset with frame_start held high -> all outputs 0, state IDLE. Release reset with frame_start=0 -> fb_we stays 0 for 100 cycles.
- No sprites (spr_on_wr=0), one frame_start:
  - first fb_we 3 cycles after the first SWEEP cycle, with fb_addr=0 and fb_data=4'h1;
  - exactly 307200 writes, last fb_addr=307199;
  - done pulses once in the cycle after the last write; busy falls with it.
- Sprite 2 hit only at WriteX=100..149, WriteY=320..419, with spr_addr = (Y-320)*50+(X-100) and a ROM model returning addr[3:0]|1:
  - fb_data = model value inside the box, BG_COLOR outside;
  - fb_addr for (100,320) = 204900.
- Sprites 0 and 1 both hit at (10,10), spr_addr0=18'd7, spr_addr1=18'd5000 -> rom_addr=7 one cycle later; the written data is ROM[7].
- Sprite 0 hit with rom_data=TRANSPARENT while sprite 1 is also hit with an opaque value -> fb_data=BG_COLOR.
- frame_start at pixel 1000 of SWEEP -> overrun=1, the sweep continues uninterrupted, and the total stays at 307200 writes. Then:
  - next frame_start in IDLE clears overrun;
  - Reset_n low at pixel 5000 -> fb_we=0 immediately and stays 0 until the next frame_start.
